// File: rtl/post_mac_interface.sv
// MAC RX classifier: steers each received frame to the IDs whose station address
// matches its destination address, or discards it and counts the drop.
module post_mac_interface #(
  parameter int AXIS_BUS_WIDTH = 64,
  parameter int AXIS_ID_WIDTH  = 4,
  localparam int NUM_AXIS_ID   = 2**AXIS_ID_WIDTH,
  localparam int KEEP_W        = AXIS_BUS_WIDTH/8
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [AXIS_BUS_WIDTH-1:0]   axis_in_tdata,
  input  logic [KEEP_W-1:0]           axis_in_tkeep,
  input  logic                        axis_in_tlast,
  input  logic                        axis_in_tvalid,
  output logic                        axis_in_tready,
  output logic [AXIS_BUS_WIDTH-1:0]   axis_out_tdata,
  output logic [NUM_AXIS_ID-1:0]      axis_out_tuser,
  output logic [AXIS_ID_WIDTH-1:0]    axis_out_tid,
  output logic [KEEP_W-1:0]           axis_out_tkeep,
  output logic                        axis_out_tlast,
  output logic                        axis_out_tvalid,
  input  logic                        axis_out_tready,
  input  logic [48*NUM_AXIS_ID-1:0]   mac_addrs,
  input  logic [NUM_AXIS_ID-1:0]      mac_en,
  output logic [31:0]                 drop_count
);

  typedef enum logic [1:0] {FIRST, FWD, DROP} state_t;

  state_t                      state;
  logic [47:0]                 da;
  logic [NUM_AXIS_ID-1:0]      hit;
  logic [NUM_AXIS_ID-1:0]      mask;
  logic                        accept;
  logic                        fwd_beat;
  logic                        drop_first;

  logic [AXIS_BUS_WIDTH-1:0]   data_p1;
  logic [KEEP_W-1:0]           keep_p1;
  logic                        last_p1;
  logic [NUM_AXIS_ID-1:0]      user_p1;
  logic [AXIS_ID_WIDTH-1:0]    tid_p1;
  logic                        vld_p1;

  function automatic logic [AXIS_ID_WIDTH-1:0] lowest_idx(input logic [NUM_AXIS_ID-1:0] m);
    logic [AXIS_ID_WIDTH-1:0] r;
    r = '0;
    for (int i = NUM_AXIS_ID-1; i >= 0; i--)
      if (m[i]) r = AXIS_ID_WIDTH'(i);
    return r;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  // Group addresses (I/G bit set, incl. broadcast) fan out to every enabled ID.
  always_comb begin
    da  = axis_in_tdata[47:0];
    hit = '0;
    for (int i = 0; i < NUM_AXIS_ID; i++)
      hit[i] = mac_en[i] && (mac_addrs[48*i +: 48] == da);
    mask = da[0] ? mac_en : hit;
  end

  // Drop path never waits on the output; first beats use the forward rule so
  // ready does not depend on the classification result.
  assign axis_in_tready = (state == DROP) || !vld_p1 || axis_out_tready;
  assign accept         = axis_in_tvalid && axis_in_tready;
  assign fwd_beat       = accept && ((state == FWD) || ((state == FIRST) && (mask != '0)));
  assign drop_first     = accept && (state == FIRST) && (mask == '0);

  // Stage p1: registered output; tuser/tid are only loaded on first beats so
  // they double as the per-frame latch.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= FIRST;
      vld_p1     <= 1'b0;
      data_p1    <= '0;
      keep_p1    <= '0;
      last_p1    <= 1'b0;
      user_p1    <= '0;
      tid_p1     <= '0;
      drop_count <= '0;
    end else begin
      if (fwd_beat) begin
        vld_p1  <= 1'b1;
        data_p1 <= axis_in_tdata;
        keep_p1 <= axis_in_tkeep;
        last_p1 <= axis_in_tlast;
        if (state == FIRST) begin
          user_p1 <= mask;
          tid_p1  <= lowest_idx(mask);
        end
      end else if (axis_out_tready) begin
        vld_p1 <= 1'b0;
      end

      if (drop_first)
        drop_count <= sat_inc(drop_count);

      if (accept) begin
        case (state)
          FIRST:     if (!axis_in_tlast) state <= (mask != '0) ? FWD : DROP;
          FWD, DROP: if (axis_in_tlast) state <= FIRST;
          default:   state <= FIRST;
        endcase
      end
    end
  end

  assign axis_out_tdata  = data_p1;
  assign axis_out_tkeep  = keep_p1;
  assign axis_out_tlast  = last_p1;
  assign axis_out_tuser  = user_p1;
  assign axis_out_tid    = tid_p1;
  assign axis_out_tvalid = vld_p1;

endmodule

// File: tb/tb_post_mac_interface.sv
// Bench for post_mac_interface: directed scenarios plus random frames checked
// against a frame-level classification model and an expected-beat queue.
module tb_post_mac_interface;

  logic         aclk = 1'b0;
  logic         aresetn;
  logic [63:0]  axis_in_tdata;
  logic [7:0]   axis_in_tkeep;
  logic         axis_in_tlast;
  logic         axis_in_tvalid;
  logic         axis_in_tready;
  logic [63:0]  axis_out_tdata;
  logic [15:0]  axis_out_tuser;
  logic [3:0]   axis_out_tid;
  logic [7:0]   axis_out_tkeep;
  logic         axis_out_tlast;
  logic         axis_out_tvalid;
  logic         axis_out_tready;
  logic [767:0] mac_addrs;
  logic [15:0]  mac_en;
  logic [31:0]  drop_count;

  always #5 aclk = ~aclk;

  post_mac_interface #(.AXIS_BUS_WIDTH(64), .AXIS_ID_WIDTH(4)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .axis_in_tdata(axis_in_tdata), .axis_in_tkeep(axis_in_tkeep),
    .axis_in_tlast(axis_in_tlast), .axis_in_tvalid(axis_in_tvalid),
    .axis_in_tready(axis_in_tready),
    .axis_out_tdata(axis_out_tdata), .axis_out_tuser(axis_out_tuser),
    .axis_out_tid(axis_out_tid), .axis_out_tkeep(axis_out_tkeep),
    .axis_out_tlast(axis_out_tlast), .axis_out_tvalid(axis_out_tvalid),
    .axis_out_tready(axis_out_tready),
    .mac_addrs(mac_addrs), .mac_en(mac_en), .drop_count(drop_count)
  );

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic [15:0] u;
    logic [3:0]  t;
  } beat_t;

  beat_t       exp_q[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] m_drop = 32'd0;
  int          rdy_mode = 0;
  int          pat_i = 0;
  bit          bp_check = 1'b0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_mask(input logic [47:0] a);
    logic [15:0] m;
    for (int i = 0; i < 16; i++)
      m[i] = a[0] ? mac_en[i] : (mac_en[i] && (mac_addrs[48*i +: 48] == a));
    return m;
  endfunction

  function automatic logic [3:0] model_tid(input logic [15:0] m);
    for (int i = 0; i < 16; i++)
      if (m[i]) return 4'(i);
    return 4'd0;
  endfunction

  // Output-side ready pattern generator.
  always @(posedge aclk) begin
    #1;
    case (rdy_mode)
      0: axis_out_tready = 1'b1;
      1: axis_out_tready = 1'($urandom % 2);
      default: begin
        axis_out_tready = (pat_i % 4 == 0) || (pat_i % 4 == 3);
        pat_i++;
      end
    endcase
  end

  beat_t got_b, held_b, exp_b;
  bit    stalled = 1'b0;

  always @(negedge aclk) begin
    if (!aresetn) begin
      stalled = 1'b0;
    end else begin
      got_b = {axis_out_tdata, axis_out_tkeep, axis_out_tlast, axis_out_tuser, axis_out_tid};
      if (stalled)
        chk("hold", 128'({axis_out_tvalid, got_b}), 128'({1'b1, held_b}));
      if (bp_check && axis_out_tvalid && !axis_out_tready)
        chk("bp_in_ready", 128'(axis_in_tready), 128'(0));
      if (axis_out_tvalid && axis_out_tready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 128'({1'b1, got_b}), 128'(0));
        end else begin
          exp_b = exp_q.pop_front();
          chk("beat", 128'(got_b), 128'(exp_b));
        end
      end
      stalled = axis_out_tvalid && !axis_out_tready;
      held_b  = got_b;
    end
  end

  task automatic send_frame(input logic [47:0] da, input int n, input int chg_at,
                            input logic [15:0] chg_en, input int cut, output int stalls);
    logic [15:0] m;
    logic [3:0]  t;
    logic [63:0] d;
    bit          acc;
    int          w;
    m = model_mask(da);
    t = model_tid(m);
    if (m == 16'd0 && m_drop != 32'hFFFF_FFFF) m_drop = m_drop + 32'd1;
    stalls = 0;
    for (int b = 0; b < n; b++) begin
      if (cut > 0 && b >= cut) break;
      if (b == chg_at) mac_en = chg_en;
      d = {$urandom, $urandom};
      if (b == 0) d[47:0] = da;
      axis_in_tdata  = d;
      axis_in_tkeep  = 8'($urandom);
      axis_in_tlast  = (b == n-1);
      axis_in_tvalid = 1'b1;
      if (m != 16'd0) exp_q.push_back({d, axis_in_tkeep, axis_in_tlast, m, t});
      w = 0;
      do begin
        @(negedge aclk);
        acc = axis_in_tready;
        @(posedge aclk);
        #1;
        if (!acc) begin stalls++; w++; end
      end while (!acc && w < 1000);
      if (!acc) chk("accept_timeout", 128'(acc), 128'(1));
    end
    axis_in_tvalid = 1'b0;
    axis_in_tlast  = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while ((exp_q.size() != 0 || axis_out_tvalid) && w < 300) begin
      @(posedge aclk);
      #1;
      w++;
    end
    chk("drain_empty", 128'(exp_q.size()), 128'(0));
  endtask

  int          st;
  logic [47:0] da;
  logic [63:0] r64;

  initial begin
    aresetn = 1'b0;
    axis_in_tdata = '0; axis_in_tkeep = '0; axis_in_tlast = 1'b0; axis_in_tvalid = 1'b0;
    axis_out_tready = 1'b1;
    mac_addrs = '0; mac_en = '0;
    repeat (3) @(posedge aclk);
    #1;
    chk("reset_state", 128'({axis_out_tvalid, axis_out_tdata, axis_out_tuser, axis_out_tid,
                             axis_out_tkeep, axis_out_tlast, drop_count}), 128'(0));
    @(negedge aclk) aresetn = 1'b1;
    @(posedge aclk); #1;

    // Unicast hit on ID 3
    mac_addrs[48*3 +: 48] = 48'h0A0B0C0D0E02;
    mac_en = 16'h0008;
    send_frame(48'h0A0B0C0D0E02, 3, -1, 16'h0, 0, st);
    chk("uni_last_latency", 128'({axis_out_tvalid, axis_out_tlast, axis_out_tuser, axis_out_tid}),
        128'({1'b1, 1'b1, 16'h0008, 4'd3}));
    drain();
    chk("uni_drop", 128'(drop_count), 128'(m_drop));

    // Broadcast
    mac_en = 16'h00A5;
    send_frame(48'hFFFFFFFFFFFF, 4, -1, 16'h0, 0, st);
    chk("bcast_tag", 128'({axis_out_tuser, axis_out_tid}), 128'({16'h00A5, 4'd0}));
    drain();

    // Miss, then a normal hit
    mac_en = 16'h0008;
    send_frame(48'h0A0B0C0D0E04, 4, -1, 16'h0, 0, st);
    chk("miss_ready_stalls", 128'(st), 128'(0));
    drain();
    chk("miss_drop", 128'(drop_count), 128'(32'd1));
    send_frame(48'h0A0B0C0D0E02, 2, -1, 16'h0, 0, st);
    drain();

    // Backpressure 1,0,0,1 pattern
    rdy_mode = 2; pat_i = 0; bp_check = 1'b1;
    send_frame(48'h0A0B0C0D0E02, 5, -1, 16'h0, 0, st);
    drain();
    bp_check = 1'b0; rdy_mode = 0;

    // mac_en change mid-frame
    mac_addrs[48*1 +: 48] = 48'h112233445566;
    mac_en = 16'h0002;
    send_frame(48'h112233445566, 4, 1, 16'h0000, 0, st);
    drain();
    send_frame(48'h112233445566, 3, -1, 16'h0, 0, st);
    drain();
    chk("midchg_drop", 128'(drop_count), 128'(m_drop));

    // Reset mid-frame on beat 2 of 4
    send_frame(48'h0000000000A0, 4, -1, 16'h0, 2, st);
    aresetn = 1'b0;
    #2;
    chk("rst_mid", 128'({axis_out_tvalid, drop_count}), 128'(0));
    exp_q.delete();
    m_drop = 32'd0;
    @(negedge aclk) aresetn = 1'b1;
    @(posedge aclk); #1;
    chk("rst_after", 128'({axis_out_tvalid, drop_count}), 128'(0));
    mac_en = 16'h0008;
    send_frame(48'h0A0B0C0D0E02, 2, -1, 16'h0, 0, st);
    drain();

    // Saturation
    @(negedge aclk);
    force dut.drop_count = 32'hFFFF_FFFF;
    @(posedge aclk);
    @(negedge aclk);
    release dut.drop_count;
    m_drop = 32'hFFFF_FFFF;
    @(posedge aclk); #1;
    chk("sat_forced", 128'(drop_count), 128'(m_drop));
    mac_en = 16'h0000;
    send_frame(48'h0A0B0C0D0E02, 1, -1, 16'h0, 0, st);
    drain();
    chk("sat_hold", 128'(drop_count), 128'(32'hFFFF_FFFF));

    // Fresh reset, then random frames under random backpressure
    @(negedge aclk) aresetn = 1'b0;
    m_drop = 32'd0;
    @(negedge aclk) aresetn = 1'b1;
    @(posedge aclk); #1;
    for (int i = 0; i < 16; i++) begin
      r64 = {$urandom, $urandom};
      mac_addrs[48*i +: 48] = r64[47:0] & 48'hFFFF_FFFF_FFFE;
    end
    rdy_mode = 1;
    for (int f = 0; f < 40; f++) begin
      mac_en = 16'($urandom);
      r64 = {$urandom, $urandom};
      case ($urandom % 4)
        0: da = mac_addrs[48*($urandom % 16) +: 48];
        1: da = 48'hFFFFFFFFFFFF;
        2: da = r64[47:0] | 48'h1;
        default: da = r64[47:0] & 48'hFFFF_FFFF_FFFE;
      endcase
      send_frame(da, $urandom_range(1, 6), ($urandom % 3 == 0) ? $urandom_range(1, 3) : -1,
                 16'($urandom), 0, st);
      chk("rand_drop", 128'(drop_count), 128'(m_drop));
    end
    drain();
    rdy_mode = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
